conv_rom_arbiter: RTL and testbench
===================================

Name: conv_rom_arbiter

Overview:
Shares the single-port image/weight ROM read port between two requesters in the conv layer: the image input interface (IMG) and the kernel weight loader (WGT). Each requester asks for a burst of consecutive words from a base address. The arbiter grants one requester at a time using round-robin, issues the ROM reads, and returns the data tagged with its owner. It sits between the conv layer controller's datapath blocks and the ROM.

Parameters:
ADDR_WIDTH, 6, ROM address width; the ROM depth is 2**ADDR_WIDTH (64).
DATA_WIDTH, 8, ROM word width.
BURST_WIDTH, 4, width of the burst length field; the maximum burst is 15 words.
ROM_LATENCY, 1, cycles from rom_rd_en to rom_data being valid; legal range 1..3.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  arbitration enable; gates new grants only
img_req  in  1  IMG burst request, held until img_gnt
img_addr  in  ADDR_WIDTH  IMG base address
img_len  in  BURST_WIDTH  IMG burst length
wgt_req  in  1  WGT burst request, held until wgt_gnt
wgt_addr  in  ADDR_WIDTH  WGT base address
wgt_len  in  BURST_WIDTH  WGT burst length
img_gnt  out  1  IMG owns the port
wgt_gnt  out  1  WGT owns the port
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ADDR_WIDTH  ROM read address
rom_data  in  DATA_WIDTH  ROM read data
rd_data  out  DATA_WIDTH  returned data, registered
rd_valid  out  1  rd_data is valid
rd_owner  out  1  owner of rd_data: 0 = IMG, 1 = WGT
burst_done  out  1  one-cycle pulse on the last word of a burst
current_state  out  2  FSM state, for debug

Behaviour:
- Reset: all outputs are 0 and the state is IDLE.
  - last_owner resets to WGT, so IMG wins the first tie.
  - The read pipeline is flushed and in-flight data is dropped.
  - Reset in the middle of a burst has the same effect; no burst_done is issued.
- States: IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- IDLE:
  - Arbitration happens only when enable=1 and at least one request is high.
  - If only one requester is asking, it wins.
  - If both are asking, the requester that is not last_owner wins.
  - On a win: latch the winner's address and length, set its gnt, and go to ISSUE.
- ISSUE:
  - rom_rd_en=1 and rom_addr = base + i for i = 0..len-1, one read per cycle.
  - The address wraps modulo 2**ADDR_WIDTH (63 is followed by 0).
  - After the last read, go to DRAIN.
- DRAIN: wait until the last word returns, then go to DONE.
- DONE: lasts one cycle. Drop gnt, update last_owner, and go to IDLE.
- Timing, with the request seen in IDLE at cycle T and burst length L:
  - gnt and the first rom_rd_en appear at T+1.
  - Reads are issued in cycles T+1 .. T+L.
  - rd_valid is high in cycles T+1+ROM_LATENCY .. T+L+ROM_LATENCY. rd_data is the registered rom_data.
  - burst_done goes high together with the last rd_valid.
  - gnt stays high from T+1 through the burst_done cycle.
  - The earliest next grant is 2 cycles after burst_done.
- rd_owner equals the latched owner whenever rd_valid=1. It holds its last value otherwise.
- Length 0: grant for one cycle with no rom_rd_en and no rd_valid. burst_done pulses at T+1, then DONE and IDLE as normal.
- enable=0:
  - No new grant is made.
  - An active burst still runs to completion.
  - A request held while disabled is granted on the first IDLE cycle with enable=1.
- A requester that drops req before grant is not served. Requests are not sampled outside IDLE.
- A requester holding req after its burst_done loses the next tie to the other requester.
- The non-granted gnt is always 0; img_gnt and wgt_gnt are never both 1.

Decomposition:
- Shared package conv_pkg holds:
  - state constants ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE;
  - owner constants OWN_IMG = 0 and OWN_WGT = 1;
  - the ADDR_WIDTH and DATA_WIDTH defaults used by conv_layer_controller and the interfaces.
- One sub-module, rom_read_pipe: a ROM_LATENCY-deep shift register carrying {valid, owner, last}. It aligns rd_valid, rd_owner and burst_done with rom_data.

Test Plan:
1. After reset, img_req=1, img_addr=5, img_len=4 → img_gnt at T+1; rom_addr = 5, 6, 7, 8; rd_valid for 4 cycles with rd_owner=0; burst_done on the 4th valid.
2. img_req and wgt_req both held, each with len=2 → order is IMG, WGT, IMG, WGT; gnts never overlap; 2-cycle gap between burst_done and the next gnt.
3. wgt_addr=62, wgt_len=4 → rom_addr = 62, 63, 0, 1; rd_owner=1.
4. img_len=0 → img_gnt high for 1 cycle; burst_done at T+1; no rom_rd_en and no rd_valid.
5. enable dropped during a 6-word burst → the burst completes. A pending wgt_req is not granted until enable=1, then is granted 1 cycle later.
6. rst pulsed on the 3rd read of an 8-word burst → the next cycle shows all outputs 0 and state IDLE; no burst_done. A following IMG/WGT tie goes to IMG.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the conv layer ROM path.
// Holds FSM state codes, owner tags and the default bus widths.
package conv_pkg;

  localparam int CONV_ADDR_WIDTH = 6;
  localparam int CONV_DATA_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IMG = 1'b0;
  localparam logic OWN_WGT = 1'b1;

  // Sideband that travels alongside each ROM read
  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/rom_read_pipe.sv
// Delays the read tag by LATENCY cycles so that rd_valid, rd_owner and
// burst_done line up with the registered copy of rom_data.
module rom_read_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  rd_tag_t               i_tag,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_valid,
  output logic                  o_owner,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_data
);

  rd_tag_t w_feed;

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_feed = i_tag;
    end else begin : g_chain
      rd_tag_t r_chain [LATENCY-1];
      for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (rst) r_chain[gi] <= '0;
            else     r_chain[gi] <= i_tag;
          end
        end else begin : g_next
          always_ff @(posedge clk) begin
            if (rst) r_chain[gi] <= '0;
            else     r_chain[gi] <= r_chain[gi-1];
          end
        end
      end
      assign w_feed = r_chain[LATENCY-2];
    end
  endgenerate

  logic                  r_valid;
  logic                  r_owner;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;

  // rom_data is captured on the edge where its tag reaches the output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_feed.valid;
      r_last  <= w_feed.valid & w_feed.last;
      if (w_feed.valid) begin
        r_owner <= w_feed.owner;
        r_data  <= i_rom_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_owner = r_owner;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/conv_rom_arbiter.sv
// Round-robin arbiter sharing the conv-layer ROM read port between the
// image interface (IMG) and the weight loader (WGT), one burst at a time.
module conv_rom_arbiter
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH  = CONV_ADDR_WIDTH,
  parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int BURST_WIDTH = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   img_req,
  input  logic [ADDR_WIDTH-1:0]  img_addr,
  input  logic [BURST_WIDTH-1:0] img_len,
  input  logic                   wgt_req,
  input  logic [ADDR_WIDTH-1:0]  wgt_addr,
  input  logic [BURST_WIDTH-1:0] wgt_len,
  output logic                   img_gnt,
  output logic                   wgt_gnt,
  output logic                   rom_rd_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_owner,
  output logic                   burst_done,
  output logic [1:0]             current_state
);

  // DRAIN covers only the ROM_LATENCY-1 cycles between the last read and the
  // burst_done cycle, which is spent in DONE; with latency 1 it is skipped.
  localparam logic [1:0] DRAIN_INIT = 2'(ROM_LATENCY > 1 ? ROM_LATENCY - 2 : 0);

  logic [1:0]             r_state;
  logic                   r_owner;
  logic                   r_last_owner;
  logic                   r_img_gnt;
  logic                   r_wgt_gnt;
  logic                   r_zero_len;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BURST_WIDTH-1:0] r_remain;
  logic [1:0]             r_drain;

  logic                   w_pick_wgt;
  logic [BURST_WIDTH-1:0] w_win_len;
  logic                   w_pipe_last;
  rd_tag_t                w_tag;

  assign w_pick_wgt = wgt_req & (~img_req | (r_last_owner == OWN_IMG));
  assign w_win_len  = w_pick_wgt ? wgt_len : img_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IMG;
      r_last_owner <= OWN_WGT;
      r_img_gnt    <= 1'b0;
      r_wgt_gnt    <= 1'b0;
      r_zero_len   <= 1'b0;
      r_addr       <= '0;
      r_remain     <= '0;
      r_drain      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && (img_req || wgt_req)) begin
            r_owner    <= w_pick_wgt ? OWN_WGT : OWN_IMG;
            r_addr     <= w_pick_wgt ? wgt_addr : img_addr;
            r_remain   <= w_win_len;
            r_zero_len <= (w_win_len == '0);
            r_img_gnt  <= ~w_pick_wgt;
            r_wgt_gnt  <= w_pick_wgt;
            r_state    <= (w_win_len == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_addr   <= r_addr + ADDR_WIDTH'(1);
          r_remain <= r_remain - BURST_WIDTH'(1);
          if (r_remain == BURST_WIDTH'(1)) begin
            r_state <= (ROM_LATENCY == 1) ? ST_DONE : ST_DRAIN;
            r_drain <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          if (r_drain == 2'd0) r_state <= ST_DONE;
          else                 r_drain <= r_drain - 2'd1;
        end
        default: begin
          r_img_gnt    <= 1'b0;
          r_wgt_gnt    <= 1'b0;
          r_zero_len   <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_tag.valid = (r_state == ST_ISSUE);
  assign w_tag.owner = r_owner;
  assign w_tag.last  = (r_remain == BURST_WIDTH'(1));

  rom_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (ROM_LATENCY)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_tag      (w_tag),
    .i_rom_data (rom_data),
    .o_valid    (rd_valid),
    .o_owner    (rd_owner),
    .o_last     (w_pipe_last),
    .o_data     (rd_data)
  );

  assign img_gnt       = r_img_gnt;
  assign wgt_gnt       = r_wgt_gnt;
  assign rom_rd_en     = w_tag.valid;
  assign rom_addr      = r_addr;
  assign burst_done    = w_pipe_last | ((r_state == ST_DONE) & r_zero_len);
  assign current_state = r_state;

endmodule

// File: tb/tb_conv_rom_arbiter.sv
// Directed bench for conv_rom_arbiter: returned words are checked against a
// scoreboard filled when each burst request is driven.
module tb_conv_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       img_req = 1'b0, wgt_req = 1'b0;
  logic [5:0] img_addr = '0, wgt_addr = '0;
  logic [3:0] img_len = '0, wgt_len = '0;
  logic       img_gnt, wgt_gnt, rom_rd_en, rd_valid, rd_owner, burst_done;
  logic [5:0] rom_addr;
  logic [7:0] rom_data, rd_data;
  logic [1:0] current_state;

  typedef struct {
    logic       own;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [5:0] a);
    return 8'({2'b00, a} * 8'd3 + 8'h11);
  endfunction

  // Single-cycle ROM (ROM_LATENCY = 1): word available before the next edge
  assign rom_data = rom_word(rom_addr);

  conv_rom_arbiter dut (
    .clk(clk), .rst(rst), .enable(enable),
    .img_req(img_req), .img_addr(img_addr), .img_len(img_len),
    .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_len(wgt_len),
    .img_gnt(img_gnt), .wgt_gnt(wgt_gnt),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_owner(rd_owner),
    .burst_done(burst_done), .current_state(current_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic own, input logic [5:0] a, input logic [3:0] l);
    for (int i = 0; i < int'(l); i++) begin
      exp_t e;
      e.own  = own;
      e.data = rom_word(6'(a + 6'(i)));
      e.last = (i == int'(l) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_img_gnt"}, img_gnt, 0);
    chk({tag, "_wgt_gnt"}, wgt_gnt, 0);
    chk({tag, "_rd_en"}, rom_rd_en, 0);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_owner"}, rd_owner, 0);
    chk({tag, "_done"}, burst_done, 0);
    chk({tag, "_state"}, current_state, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_quiet(tag);
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      tick();
      @(negedge clk);
      seen = burst_done;
    end
    chk(tag, seen, 1);
  endtask

  // Drives one request in the current IDLE cycle and checks the whole burst
  task automatic do_burst(input string tag, input logic own, input logic [5:0] a,
                          input logic [3:0] l);
    if (own) begin wgt_req = 1'b1; wgt_addr = a; wgt_len = l; end
    else     begin img_req = 1'b1; img_addr = a; img_len = l; end
    push_burst(own, a, l);
    tick();
    @(negedge clk);
    chk({tag, "_gnt"}, own ? wgt_gnt : img_gnt, 1);
    chk({tag, "_other_gnt"}, own ? img_gnt : wgt_gnt, 0);
    img_req = 1'b0;
    wgt_req = 1'b0;
    if (l == 0) begin
      chk({tag, "_zl_rd_en"}, rom_rd_en, 0);
      chk({tag, "_zl_done"}, burst_done, 1);
      chk({tag, "_zl_valid"}, rd_valid, 0);
    end else begin
      for (int i = 0; i < int'(l); i++) begin
        chk({tag, "_rd_en"}, rom_rd_en, 1);
        chk({tag, "_addr"}, rom_addr, 6'(a + 6'(i)));
        tick();
        @(negedge clk);
      end
      chk({tag, "_done"}, burst_done, 1);
      chk({tag, "_gnt_at_done"}, own ? wgt_gnt : img_gnt, 1);
    end
    tick();
    @(negedge clk);
    chk({tag, "_gnt_drop"}, img_gnt | wgt_gnt, 0);
    chk({tag, "_idle"}, current_state, 0);
  endtask

  // Scoreboard consumer plus grant-exclusivity check
  always @(negedge clk) begin
    if (!rst) begin
      if (img_gnt || wgt_gnt) chk("gnt_excl", img_gnt & wgt_gnt, 0);
      if (rd_valid) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_owner", rd_owner, e.own);
          chk("rd_last", burst_done, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int  grants, dones, last_done;
    bit  prev_gnt;
    logic exp_own;

    do_reset("reset");

    // 1: single IMG burst
    do_burst("t1", 1'b0, 6'd5, 4'd4);

    // 2: both held, alternating grants with a 2-cycle gap
    do_reset("t2_reset");
    img_req = 1'b1; img_addr = 6'd10; img_len = 4'd2;
    wgt_req = 1'b1; wgt_addr = 6'd20; wgt_len = 4'd2;
    push_burst(1'b0, 6'd10, 4'd2);
    push_burst(1'b1, 6'd20, 4'd2);
    push_burst(1'b0, 6'd10, 4'd2);
    push_burst(1'b1, 6'd20, 4'd2);
    grants = 0; dones = 0; last_done = 0; prev_gnt = 1'b0; exp_own = 1'b0;
    for (int c = 1; c <= 60 && dones < 4; c++) begin
      tick();
      @(negedge clk);
      if ((img_gnt || wgt_gnt) && !prev_gnt) begin
        chk("t2_order", wgt_gnt, exp_own);
        exp_own = ~exp_own;
        if (grants > 0) chk("t2_gap", c - last_done, 2);
        grants++;
        if (grants == 4) begin img_req = 1'b0; wgt_req = 1'b0; end
      end
      if (burst_done) begin dones++; last_done = c; end
      prev_gnt = img_gnt | wgt_gnt;
    end
    chk("t2_bursts", dones, 4);
    tick();
    @(negedge clk);

    // 3: WGT burst wrapping past the top of the ROM
    do_burst("t3", 1'b1, 6'd62, 4'd4);

    // 4: zero-length IMG burst
    do_burst("t4", 1'b0, 6'd7, 4'd0);

    // 5: enable dropped mid-burst, pending WGT waits for enable
    img_req = 1'b1; img_addr = 6'd30; img_len = 4'd6;
    push_burst(1'b0, 6'd30, 4'd6);
    tick();
    @(negedge clk);
    chk("t5_gnt", img_gnt, 1);
    img_req = 1'b0;
    enable = 1'b0;
    wgt_req = 1'b1; wgt_addr = 6'd40; wgt_len = 4'd1;
    wait_done("t5_done", 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t5_held_off", wgt_gnt, 0);
    end
    enable = 1'b1;
    push_burst(1'b1, 6'd40, 4'd1);
    tick();
    @(negedge clk);
    chk("t5_late_gnt", wgt_gnt, 1);
    wgt_req = 1'b0;
    wait_done("t5_wgt_done", 5);
    tick();
    @(negedge clk);

    // 6: reset on the 3rd read of an 8-word burst
    img_req = 1'b1; img_addr = 6'd0; img_len = 4'd8;
    push_burst(1'b0, 6'd0, 4'd8);
    tick();
    img_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t6_third_addr", rom_addr, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_quiet("t6_flush");
    img_req = 1'b1; img_addr = 6'd3; img_len = 4'd1;
    wgt_req = 1'b1; wgt_addr = 6'd4; wgt_len = 4'd1;
    push_burst(1'b0, 6'd3, 4'd1);
    tick();
    @(negedge clk);
    chk("t6_tie_img", img_gnt, 1);
    chk("t6_tie_wgt", wgt_gnt, 0);
    img_req = 1'b0;
    wgt_req = 1'b0;
    wait_done("t6_done", 5);
    tick();
    tick();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
